// File: rtl/keycode_packer.sv
// keycode_packer
// Turns a stream of single-key press/release events into four packed
// 8-bit held-key slots. Occupied slots are always contiguous from slot0.
// A code never appears twice, so consumers can scan all four bytes for
// any code they care about.
//
// The event handshake is a two-state FSM:
//   IDLE  - ready; an accepted event is latched into holding registers.
//   APPLY - not ready; the held event is applied to the slots.
// This gives at most one event every two cycles. An event accepted at
// edge N is visible on keycode/key_count at edge N+1.

module keycode_packer #(
    parameter int         NUM_SLOTS  = 4,
    parameter logic [7:0] EMPTY_CODE = 8'h00
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic [7:0]             ev_code,
    input  logic                   ev_release,
    input  logic                   clear_all,
    output logic [8*NUM_SLOTS-1:0] keycode,
    output logic [2:0]             key_count,
    output logic                   overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic       accept;
    logic [7:0] hold_code;
    logic       hold_release;

    logic [7:0] slot_q [NUM_SLOTS];
    logic [7:0] slot_d [NUM_SLOTS];
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       overflow_q;
    logic       overflow_d;

    // shift_mask[i] is set when the held code sits in slot i or below it.
    // On a release, exactly these slots take the value of their upper
    // neighbour.
    logic [NUM_SLOTS-1:0] shift_mask;
    logic                 hit;
    logic                 placed;

    assign ev_ready = (state_q == IDLE);
    assign accept   = ev_valid && ev_ready;

    // FSM state register; clear_all returns to IDLE and abandons any held event.
    always_ff @(posedge Clk) begin
        // NOTE: Sequential state uses non-blocking assignments only. Every
        // always_ff then samples the values from before the edge, whatever
        // order the simulator happens to evaluate the blocks in.
        if (Reset) begin
            state_q <= IDLE;
        end else if (clear_all) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept in IDLE, spend exactly one cycle in APPLY.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Holding registers: event fields are sampled only on the accepting edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_code    <= EMPTY_CODE;
            hold_release <= 1'b0;
        end else if (accept) begin
            hold_code    <= ev_code;
            hold_release <= ev_release;
        end
    end

    // Slot update: dedupe presses, fill the lowest empty slot, compact on release.
    always_comb begin
        // NOTE: Every variable gets a default before any branch. Without
        // defaults, a path that leaves a variable unassigned would infer a
        // latch.
        slot_d     = slot_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        hit        = 1'b0;
        placed     = 1'b0;
        shift_mask = '0;

        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit           = hit | (slot_q[i] == hold_code);
            shift_mask[i] = hit;
        end

        // An EMPTY_CODE event completes the handshake but has no effect.
        // This also keeps it from matching unoccupied slots.
        if (state_q == APPLY && hold_code != EMPTY_CODE) begin
            if (hold_release) begin
                if (hit) begin
                    for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                        if (shift_mask[i]) begin
                            slot_d[i] = slot_q[i + 1];
                        end
                    end
                    slot_d[NUM_SLOTS - 1] = EMPTY_CODE;
                    count_d               = count_q - 3'd1;
                end
            end else if (!hit) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (!placed && slot_q[i] == EMPTY_CODE) begin
                        slot_d[i] = hold_code;
                        placed    = 1'b1;
                    end
                end
                if (placed) begin
                    count_d = count_q + 3'd1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // Slot, count and overflow registers; Reset outranks clear_all.
    always_ff @(posedge Clk) begin
        // NOTE: The slot array is reset explicitly. It is only NUM_SLOTS
        // bytes, and it drives the keycode interface, which must read 0
        // straight out of reset.
        if (Reset || clear_all) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= EMPTY_CODE;
            end
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Pack the slots onto the keycode bus, with slot0 in the low byte.
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign keycode[8*g +: 8] = slot_q[g];
    end

    assign key_count = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keycode_packer.sv
// tb_keycode_packer
// Drives directed scenarios and then random event traffic into
// keycode_packer. A queue-based model of the held-key set follows the
// same input stream. A compare process checks keycode, key_count,
// overflow and ev_ready against that model on every cycle. Literal
// expectations after each directed step pin the model itself.

module tb_keycode_packer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic [7:0]  ev_code = 8'h00;
    logic        ev_release = 1'b0;
    logic        clear_all = 1'b0;
    logic [31:0] keycode;
    logic [2:0]  key_count;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int ovf_seen = 0;

    // Reference model state: the held keys in slot order, plus the event
    // that is waiting for its apply cycle.
    logic [7:0] held[$];
    bit         m_live = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] p_code;
    bit         p_rel;

    keycode_packer #(.NUM_SLOTS(4), .EMPTY_CODE(8'h00)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_release (ev_release),
        .clear_all  (clear_all),
        .keycode    (keycode),
        .key_count  (key_count),
        .overflow   (overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_keycode();
        logic [31:0] k = 32'h0;
        for (int i = 0; i < held.size() && i < 4; i++) k[8*i +: 8] = held[i];
        return k;
    endfunction

    // Apply one event to the held-key set.
    function automatic void m_apply(input logic [7:0] c, input bit rel);
        int idx = -1;
        if (c == 8'h00) return;
        foreach (held[i]) if (held[i] == c) idx = i;
        if (rel) begin
            if (idx >= 0) held.delete(idx);
        end else if (idx < 0) begin
            if (held.size() < 4) held.push_back(c);
            else m_ovf = 1'b1;
        end
    endfunction

    // Model update at every rising edge, from the inputs as presented at that edge.
    initial forever begin
        @(posedge Clk);
        if (Reset) begin
            held.delete(); m_busy = 1'b0; m_ovf = 1'b0; m_live = 1'b1;
        end else if (clear_all) begin
            held.delete(); m_busy = 1'b0; m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b0;
            if (m_busy) begin
                m_apply(p_code, p_rel);
                m_busy = 1'b0;
            end else if (ev_valid) begin
                p_code = ev_code; p_rel = ev_release; m_busy = 1'b1;
            end
        end
    end

    // Compare DUT outputs against the model on each falling edge.
    initial forever begin
        @(negedge Clk);
        if (m_live) begin
            check("keycode",   keycode,            m_keycode());
            check("key_count", {29'b0, key_count}, held.size());
            check("overflow",  {31'b0, overflow},  {31'b0, m_ovf});
            check("ev_ready",  {31'b0, ev_ready},  {31'b0, !m_busy});
        end
        if (overflow === 1'b1) ovf_seen++;
    end

    // Inputs change only at the driving point, 1 time unit after a falling edge.
    task automatic idle(input int n);
        repeat (n) begin @(negedge Clk); #1; end
    endtask

    task automatic send(input logic [7:0] c, input bit rel);
        bit got = 1'b0;
        ev_valid = 1'b1; ev_code = c; ev_release = rel;
        for (int k = 0; k < 8 && !got; k++) begin
            if (ev_ready) got = 1'b1;
            idle(1);
        end
        ev_valid = 1'b0;
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: code %h never accepted", c);
        end
    endtask

    task automatic pulse_reset();
        Reset = 1'b1; idle(1); Reset = 1'b0; idle(1);
    endtask

    logic [7:0] burst [8] = '{8'h4F, 8'hAA, 8'h50, 8'hBB, 8'h51, 8'hCC, 8'h1A, 8'hDD};
    logic [7:0] pool  [8] = '{8'h00, 8'h4F, 8'h50, 8'h51, 8'h52, 8'h1A, 8'h07, 8'h29};

    initial begin
        int base;
        int acc;
        idle(2);
        check("rst_keycode",  keycode, 32'h0);
        check("rst_count",    {29'b0, key_count}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        Reset = 1'b0;
        idle(1);
        check("rst_ready", {31'b0, ev_ready}, 32'd1);

        // Single press appears one edge after acceptance.
        send(8'h52, 1'b0); idle(1);
        check("t1_keycode", keycode, 32'h00000052);
        check("t1_count",   {29'b0, key_count}, 32'd1);
        check("t1_ready",   {31'b0, ev_ready}, 32'd1);

        // Fill all four slots; a fifth press overflows for exactly one cycle.
        send(8'h52, 1'b0); send(8'h50, 1'b0); send(8'h51, 1'b0); send(8'h4F, 1'b0); idle(1);
        check("t2_full", keycode, 32'h4F515052);
        check("t2_count", {29'b0, key_count}, 32'd4);
        base = ovf_seen;
        send(8'h1A, 1'b0); idle(1);
        check("t2_ovf_hi", {31'b0, overflow}, 32'd1);
        idle(1);
        check("t2_ovf_lo", {31'b0, overflow}, 32'd0);
        check("t2_ovf_pulses", ovf_seen - base, 32'd1);
        check("t2_unchanged", keycode, 32'h4F515052);

        // A release compacts the slots; the next press fills the top slot.
        send(8'h50, 1'b1); idle(1);
        check("t3_release", keycode, 32'h004F5152);
        check("t3_count",   {29'b0, key_count}, 32'd3);
        send(8'h1A, 1'b0); idle(1);
        check("t3_refill",  keycode, 32'h1A4F5152);

        // A duplicate press, an absent release and an empty code change nothing.
        pulse_reset();
        base = ovf_seen;
        send(8'h52, 1'b0); send(8'h52, 1'b0); send(8'h07, 1'b1); send(8'h00, 1'b0); idle(2);
        check("t4_keycode", keycode, 32'h00000052);
        check("t4_count",   {29'b0, key_count}, 32'd1);
        check("t4_no_ovf",  ovf_seen - base, 32'd0);

        // Continuous ev_valid: one acceptance every 2 cycles; codes presented
        // during APPLY are ignored.
        base = ovf_seen; acc = 0;
        for (int k = 0; k < 8; k++) begin
            ev_valid = 1'b1; ev_code = burst[k]; ev_release = 1'b0;
            if (ev_ready) acc++;
            idle(1);
        end
        ev_valid = 1'b0;
        check("t5_accepted", acc, 32'd4);
        check("t5_keycode",  keycode, 32'h51504F52);
        check("t5_ovf",      ovf_seen - base, 32'd1);
        idle(1);

        // clear_all during the APPLY cycle of a press discards that press.
        pulse_reset();
        send(8'h52, 1'b0); send(8'h50, 1'b0); send(8'h51, 1'b0);
        send(8'h4F, 1'b0);
        clear_all = 1'b1; idle(1); clear_all = 1'b0;
        check("t6_keycode", keycode, 32'h0);
        check("t6_count",   {29'b0, key_count}, 32'd0);
        check("t6_ready",   {31'b0, ev_ready}, 32'd1);
        idle(1);
        check("t6_discard", keycode, 32'h0);

        // Reset and clear_all asserted together give the reset values.
        send(8'h52, 1'b0); send(8'h50, 1'b0); send(8'h51, 1'b0); idle(1);
        Reset = 1'b1; clear_all = 1'b1; idle(1); Reset = 1'b0; clear_all = 1'b0;
        check("t7_keycode", keycode, 32'h0);
        check("t7_ready",   {31'b0, ev_ready}, 32'd1);

        // Random traffic with occasional clear_all and Reset.
        for (int n = 0; n < 4000; n++) begin
            Reset      = ($urandom_range(0, 199) == 0);
            clear_all  = ($urandom_range(0, 59) == 0);
            ev_valid   = ($urandom_range(0, 3) != 0);
            ev_code    = pool[$urandom_range(0, 7)];
            ev_release = ($urandom_range(0, 2) == 0);
            idle(1);
        end
        Reset = 1'b0; clear_all = 1'b0; ev_valid = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
